// File: rtl/ram_writer.sv
// Frame-buffer fill: packs UART bytes MSB-first into RAM words written at sequential addresses.
// Optional inter-byte idle timeout is enabled by defining RAM_WRITER_TIMEOUT_EN.
module ram_writer #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = (480*360*24)/RAM_WIDTH,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int BYTES_PER_WORD = RAM_WIDTH/8,
    localparam int ADDR_BITS      = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 frame_start,
    output logic [ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 we,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 sync_err
);

    localparam int CNT_BITS = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_BITS-1:0]  LAST_CNT  = CNT_BITS'(BYTES_PER_WORD-1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_DEPTH-1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  address_q, address_d;
    logic [RAM_WIDTH-1:0]  data_out_q, data_out_d;
    logic                  we_q, we_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_BITS-1:0]   byte_cnt_q, byte_cnt_d;
    logic [RAM_WIDTH-1:0]  shift_q, shift_d;

    logic [RAM_WIDTH+7:0]  shift_ext;
    logic [RAM_WIDTH-1:0]  shift_next;
    logic                  accept;
    logic                  last_slot_busy;

`ifdef RAM_WRITER_TIMEOUT_EN
    localparam int IDLE_BITS = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(TIMEOUT_CYCLES-1);

    logic [IDLE_BITS-1:0]  idle_q, idle_d;
    logic                  sync_err_q, sync_err_d;
`endif

    // Dropping the top byte of {shift, rx_data} keeps this valid for 8-bit words too.
    assign shift_ext  = {shift_q, rx_data};
    assign shift_next = shift_ext[RAM_WIDTH-1:0];

    assign accept = rx_valid && (state_q != ST_DONE);

    // Only reachable with single-byte words: a byte landing while the final slot is written.
    assign last_slot_busy = (state_q == ST_WRITE) && (address_q == LAST_ADDR);

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        data_out_d   = data_out_q;
        we_d         = 1'b0;
        frame_done_d = frame_done_q;
        overrun_d    = overrun_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
`ifdef RAM_WRITER_TIMEOUT_EN
        idle_d       = idle_q;
        sync_err_d   = 1'b0;
`endif

        if (frame_start) begin
            state_d      = ST_COLLECT;
            address_d    = '0;
            byte_cnt_d   = '0;
            frame_done_d = 1'b0;
            overrun_d    = 1'b0;
`ifdef RAM_WRITER_TIMEOUT_EN
            idle_d       = '0;
`endif
        end else begin
            if (state_q == ST_WRITE) begin
                if (address_q == LAST_ADDR) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    address_d = address_q + 1'b1;
                    state_d   = ST_COLLECT;
                end
            end

            if ((state_q == ST_DONE) && rx_valid) begin
                overrun_d = 1'b1;
            end

            if (accept) begin
                shift_d = shift_next;
                if ((byte_cnt_q == LAST_CNT) && !last_slot_busy) begin
                    byte_cnt_d = '0;
                    data_out_d = shift_next;
                    we_d       = 1'b1;
                    state_d    = ST_WRITE;
                end else if (byte_cnt_q != LAST_CNT) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end

`ifdef RAM_WRITER_TIMEOUT_EN
            if (rx_valid) begin
                idle_d = '0;
            end else if ((state_q == ST_COLLECT) && (byte_cnt_q != '0)) begin
                if (idle_q == IDLE_LAST) begin
                    idle_d     = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    sync_err_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end else begin
                idle_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            address_q    <= '0;
            data_out_q   <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            data_out_q   <= data_out_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
        end
    end

`ifdef RAM_WRITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            idle_q     <= idle_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`else
    // No timeout: a partial word waits forever, so nothing is ever discarded.
    assign sync_err = (TIMEOUT_CYCLES < 0);
`endif

    assign address    = address_q;
    assign data_out   = data_out_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ram_writer.sv
// Scoreboard bench for ram_writer: byte-level reference model, write queue, status checks.
// Small RAM_DEPTH so frame completion, overrun and restart are exercised often.
module tb_ram_writer;

    localparam int W   = 32;
    localparam int BPW = W/8;
    localparam int D   = 4;
    localparam int AB  = $clog2(D);
    localparam int TO  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_start;
    logic [AB-1:0] address;
    logic [W-1:0]  data_out;
    logic          we;
    logic          frame_done;
    logic          overrun;
    logic          sync_err;

    always #5 clk = ~clk;

    ram_writer #(
        .RAM_WIDTH      (W),
        .RAM_DEPTH      (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .address     (address),
        .data_out    (data_out),
        .we          (we),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .sync_err    (sync_err)
    );

    typedef struct {
        int          addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         sync_pulses = 0;
    bit         chk_sync = 1'b1;

    // Reference model: words written so far, bytes of the word in progress.
    int         m_idx;
    logic [7:0] m_part[$];
    bit         m_done;
    bit         m_ovr;
    bit         m_wr;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_idx  = 0;
        m_part.delete();
        m_done = 1'b0;
        m_ovr  = 1'b0;
        m_wr   = 1'b0;
    endfunction

    function automatic void model_step(bit fs, bit rv, bit r, logic [7:0] b);
        bit           was_wr;
        bit           done_before;
        logic [W-1:0] w;
        if (r || fs) begin
            model_reset();
            return;
        end
        was_wr      = m_wr;
        m_wr        = 1'b0;
        done_before = m_done;
        if (rv) begin
            if (done_before) begin
                m_ovr = 1'b1;
            end else begin
                m_part.push_back(b);
                if (m_part.size() == BPW) begin
                    w = '0;
                    foreach (m_part[i]) w = (w << 8) | W'(m_part[i]);
                    exp_q.push_back('{m_idx, w});
                    m_idx++;
                    m_part.delete();
                    m_wr = 1'b1;
                end
            end
        end
        if (was_wr && m_idx == D) m_done = 1'b1;
    endfunction

    function automatic int exp_addr();
        if (m_wr) return m_idx - 1;
        if (m_done) return D - 1;
        return m_idx;
    endfunction

    task automatic step(bit fs, bit rv, bit r, logic [7:0] b);
        @(negedge clk);
        check("we", we, m_wr);
        check("frame_done", frame_done, m_done);
        check("overrun", overrun, m_ovr);
        check("address", address, exp_addr());
        if (chk_sync) check("sync_err", sync_err, 0);
        rst         = r;
        frame_start = fs;
        rx_valid    = rv;
        rx_data     = b;
        model_step(fs, rv, r, b);
    endtask

    task automatic send(logic [7:0] b);
        step(1'b0, 1'b1, 1'b0, b);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_rst();
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic send_word(logic [31:0] v);
        for (int i = 3; i >= 0; i--) send(v[i*8 +: 8]);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (sync_err === 1'b1) sync_pulses++;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: address %0h data %0h, none expected",
                         address, data_out);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", address, e.addr);
                check("write_data", data_out, e.data);
            end
        end
    end

    initial begin
        int r;
        int idle_run;
        int p0;

        rst         = 1'b1;
        frame_start = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_address", address, 0);
        check("rst_data_out", data_out, 0);
        check("rst_we", we, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sync_err", sync_err, 0);
        model_reset();

        step(1'b0, 1'b0, 1'b0, 8'h00);
        send_word(32'h11223344);
        idle(3);

        do_rst();
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        idle(3);

        do_rst();
        for (int i = 0; i < 16; i++) send(8'(i * 17 + 3));
        idle(1);
        send(8'h99);
        idle(2);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        send_word(32'hDEADBEEF);
        idle(3);

        do_rst();
        send(8'hF1);
        send(8'hF2);
        do_rst();
        send_word(32'h01020304);
        idle(3);

`ifdef RAM_WRITER_TIMEOUT_EN
        do_rst();
        send(8'hC1);
        send(8'hC2);
        chk_sync = 1'b0;
        p0 = sync_pulses;
        idle(TO);
        m_part.delete();
        send_word(32'h55667788);
        idle(3);
        check("sync_err_pulses", sync_pulses - p0, 1);
        chk_sync = 1'b1;
`endif

        idle_run = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (idle_run >= 3 || (r >= 4 && r < 66)) begin
                send(8'($urandom));
                idle_run = 0;
            end else if (r < 1) begin
                do_rst();
                idle_run++;
            end else if (r < 4) begin
                step(1'b1, 1'($urandom), 1'b0, 8'($urandom));
                idle_run++;
            end else begin
                idle(1);
                idle_run++;
            end
        end
        idle(3);
        check("pending_writes", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
